byte_data_memory: RTL and testbench
===================================

# byte_data_memory

Parametrised, multi-cycle data memory for the single-cycle/multi-cycle MIPS datapath. It replaces the fixed 1K x 32 word-only memory and adds:
- byte, halfword and word accesses, with sign/zero extension on loads;
- alignment checking;
- a configurable access latency with a request/Ready handshake, so the controller can model a slow memory.

## Interface
Parameters:
- ADDR_BITS, 10, word-index width; depth = 2^ADDR_BITS 32-bit words; word index = Address[ADDR_BITS+1:2].
- LATENCY, 2, extra wait cycles per access; legal range 0..15.

Ports (one clock; reset is synchronous and active-high):
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous active-high reset.
- Address  input  32  byte address.
- WriteData  input  32  store data; the low byte/halfword is used for narrow stores.
- MemWrite  input  1  store request.
- MemRead  input  1  load request.
- Size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- Unsigned  input  1  selects zero extension for narrow loads; otherwise sign extension.
- ReadData  output  32  load result; registered.
- Ready  output  1  one-cycle completion pulse.
- Misaligned  output  1  error flag; valid only while Ready=1.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If exactly one of MemRead/MemWrite is 1, the request is accepted at the clock edge.
  - Address, WriteData, Size, Unsigned and direction are captured at acceptance.
  - Go to WAIT with the counter loaded to LATENCY; if LATENCY=0, go straight to DONE.
- WAIT: the counter decrements each cycle; at 0 the access is performed and the FSM moves to DONE. Request inputs are ignored while in WAIT.
- DONE: Ready=1 for exactly one cycle, then return to IDLE. A request present during DONE is not accepted.
- Both MemRead and MemWrite = 1 in IDLE: accepted as an error access. No write occurs; it completes with Misaligned=1 and ReadData=0.
- Alignment errors:
  - Halfword with Address[0]=1, word with Address[1:0]!=00, and Size=11 are all errors.
  - An error access performs no write and completes with Misaligned=1. For loads, ReadData=0.
  - Error accesses take the same latency as legal ones.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by Address[1:0]. Halfword lanes are selected by Address[1].
- Stores:
  - Byte: WriteData[7:0] goes to the addressed lane.
  - Halfword: WriteData[15:0] goes to the addressed half.
  - Word: full 32 bits.
  - Other lanes are unchanged.
- Loads: the selected byte/half is right-justified, then sign-extended (Unsigned=0) or zero-extended (Unsigned=1). Word loads are returned unchanged.
- Address bits above ADDR_BITS+1 are ignored, so addresses alias modulo 2^(ADDR_BITS+2).
- Memory contents are not cleared by Reset and are undefined at power-up; the bench must store before loading.
- ReadData:
  - updates only on completion of a load;
  - is held through stores and idle cycles;
  - returns 0 on completion of an error load.

## Timing
- Reset values: state IDLE, counter 0, Ready 0, Misaligned 0, ReadData 0x00000000.
- Request accepted at edge N → Ready high in cycle N+1+LATENCY, with ReadData and Misaligned valid in the same cycle.
- The store becomes visible to a load accepted at or after the edge that ends the Ready cycle.
- Throughput: one access per LATENCY+2 cycles, including the mandatory idle cycle after DONE.
- Reset asserted in WAIT or DONE: the access is aborted, any pending write is discarded, and Ready is 0 in the following cycle.
- Reset has priority over a request in the same cycle.

## Test plan
- Word round trip, LATENCY=2:
  - store 0xDEADBEEF at 0x10, then load word 0x10;
  - Ready pulses 3 cycles after each acceptance; ReadData=0xDEADBEEF; Misaligned=0.
- Narrow stores/loads after word 0x00000000 at 0x20:
  - store byte 0x80 at 0x23, then store half 0x1234 at 0x20 → word reads 0x80001234;
  - load byte 0x23 signed → 0xFFFFFF80; unsigned → 0x00000080;
  - load half 0x22 signed → 0xFFFF8000.
- Misalignment:
  - store word 0xAAAAAAAA at 0x31 → Misaligned=1 and word 0x30 unchanged;
  - load half 0x33 → Misaligned=1, ReadData=0;
  - Size=11 → Misaligned=1.
- Conflicting request: MemRead=MemWrite=1 at 0x40 holding 0x5 → Misaligned=1, memory still reads 0x5.
- Reset mid-access: store 0x77 to 0x50 (old 0x11), assert Reset during WAIT → no Ready pulse, ReadData=0, and a later load 0x50 returns 0x11.
- Parameter sweep:
  - LATENCY=0 → Ready exactly 1 cycle after acceptance;
  - ADDR_BITS=4 → a store to 0x40 aliases to word 0.

Source files
------------

// File: rtl/byte_data_memory.sv
// Multi-cycle data memory with byte/halfword/word access, load extension,
// alignment checking and a configurable-latency request/Ready handshake.
module byte_data_memory #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Misaligned
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned AW    = ADDR_BITS + 2;
    localparam int unsigned CW    = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [1:0]     size_q, size_d;
    logic           uns_q, uns_d;
    logic           write_q, write_d;
    logic           err_q, err_d;
    logic [31:0]    read_data_q, read_data_d;
    logic           ready_q, ready_d;
    logic           misaligned_q, misaligned_d;

    logic [31:0]    mem [DEPTH];
    logic           perform;
    logic           align_err;
    logic           mem_we;
    logic [3:0]     be;
    logic [31:0]    wr_word;
    logic [31:0]    rd_word;
    logic [7:0]     rd_byte;
    logic [15:0]    rd_half;
    logic [31:0]    load_val;
    logic           unused_addr_bits;

    // Upper address bits only alias; they never select storage.
    assign unused_addr_bits = ^Address[31:AW];

    // Alignment / size legality of the incoming request.
    always_comb begin
        align_err = 1'b0;
        case (Size)
            2'b00:   align_err = 1'b0;
            2'b01:   align_err = Address[0];
            2'b10:   align_err = |Address[1:0];
            default: align_err = 1'b1;
        endcase
    end

    // Handshake FSM; the *_d request fields always describe the access in flight,
    // which lets a zero-latency access complete on its own acceptance edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        write_d = write_q;
        err_d   = err_q;
        perform = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d  = Address[AW-1:0];
                    wdata_d = WriteData;
                    size_d  = Size;
                    uns_d   = Unsigned;
                    write_d = MemWrite & ~MemRead;
                    err_d   = (MemRead & MemWrite) | align_err;
                    if (LATENCY == 0) begin
                        state_d = S_DONE;
                        perform = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(LATENCY);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    perform = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Store lane steering: narrow data is replicated, byte enables pick the lane.
    always_comb begin
        be      = 4'b0000;
        wr_word = wdata_d;
        case (size_d)
            2'b00: begin
                be      = 4'b0001 << addr_d[1:0];
                wr_word = {4{wdata_d[7:0]}};
            end
            2'b01: begin
                be      = addr_d[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_d[15:0]}};
            end
            2'b10: begin
                be = 4'b1111;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

    assign mem_we = perform & write_d & ~err_d & ~Reset;

    // Load extraction with sign or zero extension.
    always_comb begin
        rd_word  = mem[addr_d[AW-1:2]];
        rd_byte  = rd_word[{addr_d[1:0], 3'b000} +: 8];
        rd_half  = rd_word[{addr_d[1], 4'b0000} +: 16];
        load_val = rd_word;
        case (size_d)
            2'b00:   load_val = uns_d ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_val = uns_d ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Completion outputs; ReadData only moves when a load finishes.
    always_comb begin
        read_data_d  = read_data_q;
        ready_d      = perform;
        misaligned_d = perform & err_d;
        if (perform && !write_d) begin
            read_data_d = err_d ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            read_data_q  <= '0;
            ready_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            write_q      <= write_d;
            err_q        <= err_d;
            read_data_q  <= read_data_d;
            ready_q      <= ready_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Storage is never cleared by reset.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[addr_d[AW-1:2]][8*k +: 8] <= wr_word[8*k +: 8];
                end
            end
        end
    end

    assign ReadData   = read_data_q;
    assign Ready      = ready_q;
    assign Misaligned = misaligned_q;

endmodule

// File: tb/tb_byte_data_memory.sv
// Directed and randomized bench for byte_data_memory against a byte-addressed
// reference model; one instance at LATENCY=2, one at LATENCY=0 / ADDR_BITS=4.
module tb_byte_data_memory;

    localparam int LAT_A  = 2;
    localparam int LAT_B  = 0;
    localparam int SPAN_A = 4096;
    localparam int SPAN_B = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [1:0]  size;
    logic        uns_sig;
    logic        wr_a, rd_a, wr_b, rd_b;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, mis_a, mis_b;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_a [int];
    logic [7:0]  mem_b [int];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    byte_data_memory #(.ADDR_BITS(10), .LATENCY(LAT_A)) u_dut_a (
        .Clk(clk), .Reset(reset), .Address(address), .WriteData(write_data),
        .MemWrite(wr_a), .MemRead(rd_a), .Size(size), .Unsigned(uns_sig),
        .ReadData(rdata_a), .Ready(ready_a), .Misaligned(mis_a)
    );

    byte_data_memory #(.ADDR_BITS(4), .LATENCY(LAT_B)) u_dut_b (
        .Clk(clk), .Reset(reset), .Address(address), .WriteData(write_data),
        .MemWrite(wr_b), .MemRead(rd_b), .Size(size), .Unsigned(uns_sig),
        .ReadData(rdata_b), .Ready(ready_b), .Misaligned(mis_b)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_store(input int d, input int key, input logic [31:0] wd, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'((wd >> (8 * i)) & 32'hFF);
            if (d == 0) mem_a[key + i] = b;
            else        mem_b[key + i] = b;
        end
    endfunction

    function automatic logic [31:0] model_load(input int d, input int key, input int n, input logic uns);
        longint v;
        v = 0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = (d == 0) ? mem_a[key + i] : mem_b[key + i];
            v = v + (longint'(b) << (8 * i));
        end
        if (!uns && n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
        return 32'(v);
    endfunction

    // One complete access: predict, drive, wait for Ready, compare, step past DONE.
    task automatic access(input int d, input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                          input string tag, output logic [31:0] obs_rd);
        int          lat;
        int          span;
        int          n;
        int          key;
        int          cyc;
        logic        err;
        logic [31:0] exp_rd;
        lat  = (d == 0) ? LAT_A : LAT_B;
        span = (d == 0) ? SPAN_A : SPAN_B;
        n    = 1 << sz;
        key  = int'(addr % 32'(span));
        err  = (wr && rd) || (sz == 2'b11) || ((int'(addr[2:0]) % n) != 0);
        exp_rd = last_rd[d];
        if (wr && !rd && !err) model_store(d, key, wd, n);
        else if (rd) exp_rd = err ? 32'h0 : model_load(d, key, n, uns);

        @(negedge clk);
        address    = addr;
        write_data = wd;
        size       = sz;
        uns_sig    = uns;
        if (d == 0) begin wr_a = wr; rd_a = rd; end
        else        begin wr_b = wr; rd_b = rd; end
        @(posedge clk);
        #1;
        wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
        address    = $urandom;
        write_data = $urandom;
        size       = 2'($urandom_range(0, 3));
        uns_sig    = 1'($urandom_range(0, 1));
        cyc = 1;
        while (((d == 0) ? ready_a : ready_b) !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(lat + 1));
        chk({tag, "_misaligned"}, 32'((d == 0) ? mis_a : mis_b), 32'(err));
        obs_rd = (d == 0) ? rdata_a : rdata_b;
        chk({tag, "_readdata"}, obs_rd, exp_rd);
        @(posedge clk);
        #1;
        chk({tag, "_ready_pulse"}, 32'((d == 0) ? ready_a : ready_b), 32'h0);
        last_rd[d] = exp_rd;
    endtask

    initial begin
        logic [31:0] o;
        reset = 1'b1;
        address = '0; write_data = '0; size = '0; uns_sig = 1'b0;
        wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready_a", 32'(ready_a), 32'h0);
        chk("reset_mis_a", 32'(mis_a), 32'h0);
        chk("reset_rdata_a", rdata_a, 32'h0);
        chk("reset_ready_b", 32'(ready_b), 32'h0);
        chk("reset_rdata_b", rdata_b, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Word round trip.
        access(0, 1, 0, 32'h10, 32'hDEADBEEF, 2'b10, 0, "st_w10", o);
        access(0, 0, 1, 32'h10, 32'h0, 2'b10, 0, "ld_w10", o);
        chk("plan_w10", o, 32'hDEADBEEF);

        // Narrow stores and loads.
        access(0, 1, 0, 32'h20, 32'h0, 2'b10, 0, "st_w20", o);
        access(0, 1, 0, 32'h23, 32'hFFFFFF80, 2'b00, 0, "st_b23", o);
        access(0, 1, 0, 32'h20, 32'hABCD1234, 2'b01, 0, "st_h20", o);
        access(0, 0, 1, 32'h20, 32'h0, 2'b10, 0, "ld_w20", o);
        chk("plan_w20", o, 32'h80001234);
        access(0, 0, 1, 32'h23, 32'h0, 2'b00, 0, "ld_b23s", o);
        chk("plan_b23s", o, 32'hFFFFFF80);
        access(0, 0, 1, 32'h23, 32'h0, 2'b00, 1, "ld_b23u", o);
        chk("plan_b23u", o, 32'h00000080);
        access(0, 0, 1, 32'h22, 32'h0, 2'b01, 0, "ld_h22s", o);
        chk("plan_h22s", o, 32'hFFFF8000);

        // Misalignment and illegal size.
        access(0, 1, 0, 32'h30, 32'h13572468, 2'b10, 0, "st_w30", o);
        access(0, 1, 0, 32'h31, 32'hAAAAAAAA, 2'b10, 0, "st_w31_bad", o);
        access(0, 0, 1, 32'h30, 32'h0, 2'b10, 0, "ld_w30", o);
        chk("plan_w30_unchanged", o, 32'h13572468);
        access(0, 0, 1, 32'h33, 32'h0, 2'b01, 0, "ld_h33_bad", o);
        chk("plan_h33_zero", o, 32'h0);
        access(0, 0, 1, 32'h30, 32'h0, 2'b11, 0, "ld_sz3_bad", o);
        access(0, 1, 0, 32'h30, 32'hFFFFFFFF, 2'b11, 0, "st_sz3_bad", o);
        access(0, 0, 1, 32'h30, 32'h0, 2'b10, 0, "ld_w30_again", o);
        chk("plan_w30_sz3", o, 32'h13572468);

        // Conflicting request.
        access(0, 1, 0, 32'h40, 32'h5, 2'b10, 0, "st_w40", o);
        access(0, 1, 1, 32'h40, 32'h99, 2'b10, 0, "rw_w40_bad", o);
        access(0, 0, 1, 32'h40, 32'h0, 2'b10, 0, "ld_w40", o);
        chk("plan_w40", o, 32'h5);

        // Reset during WAIT aborts the store.
        access(0, 1, 0, 32'h50, 32'h11, 2'b10, 0, "st_w50", o);
        @(negedge clk);
        address = 32'h50; write_data = 32'h77; size = 2'b10; wr_a = 1'b1;
        @(posedge clk);
        #1;
        wr_a  = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", 32'(ready_a), 32'h0);
        chk("rst_rdata", rdata_a, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("rst_no_ready", 32'(ready_a), 32'h0);
        end
        last_rd[0] = '0; last_rd[1] = '0;
        access(0, 0, 1, 32'h50, 32'h0, 2'b10, 0, "ld_w50", o);
        chk("plan_w50_old", o, 32'h11);

        // Zero latency and 16-word aliasing.
        access(1, 1, 0, 32'h40, 32'hCAFEF00D, 2'b10, 0, "b_st_w40", o);
        access(1, 0, 1, 32'h00, 32'h0, 2'b10, 0, "b_ld_w00", o);
        chk("plan_alias", o, 32'hCAFEF00D);
        access(1, 0, 1, 32'h01, 32'h0, 2'b00, 0, "b_ld_b01", o);
        access(1, 0, 1, 32'h02, 32'h0, 2'b01, 1, "b_ld_h02u", o);
        access(1, 1, 0, 32'h06, 32'h1, 2'b10, 0, "b_st_w06_bad", o);

        // Randomized mix over a preloaded region, with aliased upper address bits.
        for (int i = 0; i < 16; i++) begin
            access(0, 1, 0, 32'h100 + 32'(4 * i), $urandom, 2'b10, 0, "rnd_init", o);
        end
        for (int i = 0; i < 80; i++) begin
            int          op;
            logic [31:0] a;
            logic        wr;
            logic        rd;
            op = $urandom_range(0, 9);
            a  = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << 12);
            wr = (op < 4) || (op == 9);
            rd = (op >= 4);
            access(0, wr, rd, a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd", o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
